// File: rtl/chess_line_scorer.sv
//------------------------------------------------------------------------------
// Module   : chess_line_scorer
// Brief    : Time-multiplexed Gobang point evaluator; scores four line
//            directions for attack and defence, sums with saturation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module chess_line_scorer #(
   parameter int R         = 4,
   parameter int SCORE_W   = 16,
   parameter int DEF_SHIFT = 1,
   parameter int S_FIVE    = 2500,
   parameter int S_LFOUR   = 216,
   parameter int S_SFOUR   = 36,
   parameter int S_LTHREE  = 36,
   parameter int S_LTWO    = 6,
   parameter int S_LONE    = 1,
   parameter int S_NONE    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*(2*R+1)-1:0]   in_my,
   input  logic [4*(2*R+1)-1:0]   in_op,
   input  logic [4*(2*R+1)-1:0]   in_gr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SCORE_W-1:0]     out_score,
   output logic                   out_win,
   output logic                   out_block
);

   localparam int W     = 2*R + 1;
   localparam int ACC_W = SCORE_W + 2;
   localparam int SUM_W = SCORE_W + 3;

   localparam logic [W-1:0]     c_centre = W'(1) << R;
   localparam logic [SUM_W-1:0] c_max    = {3'b000, {SCORE_W{1'b1}}};

   localparam logic [2:0] c_none   = 3'd0;
   localparam logic [2:0] c_lone   = 3'd1;
   localparam logic [2:0] c_ltwo   = 3'd2;
   localparam logic [2:0] c_lthree = 3'd3;
   localparam logic [2:0] c_sfour  = 3'd4;
   localparam logic [2:0] c_lfour  = 3'd5;
   localparam logic [2:0] c_five   = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Best pattern over all 5- and 6-cell windows that cover the centre cell.
   function automatic logic [2:0] classify(input logic [W-1:0] mine,
                                           input logic [W-1:0] blk);
      logic [W-1:0] emp, m_sh, e_sh, b_sh;
      logic f5, f4l, f4s, f3, f2, f1;
      emp = ~mine & ~blk;
      f5 = 1'b0; f4l = 1'b0; f4s = 1'b0; f3 = 1'b0; f2 = 1'b0; f1 = 1'b0;
      for (int s = 0; s <= W-5; s++) begin
         if (s <= R && s + 4 >= R) begin
            m_sh = mine >> s;
            e_sh = emp >> s;
            b_sh = blk >> s;
            if (&m_sh[4:0]) f5 = 1'b1;
            if ($countones(m_sh[4:0]) == 4 && $countones(e_sh[4:0]) == 1 &&
                b_sh[4:0] == 5'd0) f4s = 1'b1;
            if (b_sh[4:0] == 5'd0) f1 = 1'b1;
         end
      end
      for (int s = 0; s <= W-6; s++) begin
         if (s <= R && s + 5 >= R) begin
            m_sh = mine >> s;
            e_sh = emp >> s;
            if (e_sh[0] && e_sh[5]) begin
               if (&m_sh[4:1]) f4l = 1'b1;
               if ($countones(m_sh[4:1]) == 3 && $countones(e_sh[4:1]) == 1) f3 = 1'b1;
               if ($countones(m_sh[4:1]) == 2 && $countones(e_sh[4:1]) == 2) f2 = 1'b1;
            end
         end
      end
      if (f5)       classify = c_five;
      else if (f4l) classify = c_lfour;
      else if (f4s) classify = c_sfour;
      else if (f3)  classify = c_lthree;
      else if (f2)  classify = c_ltwo;
      else if (f1)  classify = c_lone;
      else          classify = c_none;
   endfunction

   function automatic logic [ACC_W-1:0] score_of(input logic [2:0] code);
      case (code)
         c_five:   score_of = ACC_W'(S_FIVE);
         c_lfour:  score_of = ACC_W'(S_LFOUR);
         c_sfour:  score_of = ACC_W'(S_SFOUR);
         c_lthree: score_of = ACC_W'(S_LTHREE);
         c_ltwo:   score_of = ACC_W'(S_LTWO);
         c_lone:   score_of = ACC_W'(S_LONE);
         default:  score_of = ACC_W'(S_NONE);
      endcase
   endfunction

   state_t             r_state;
   logic [1:0]         r_dir;
   logic [4*W-1:0]     r_my, r_op, r_gr;
   logic [ACC_W-1:0]   r_att_acc, r_def_acc;

   logic [W-1:0]       w_my_d, w_op_d, w_gr_d;
   logic [2:0]         w_att_code, w_def_code;
   logic [ACC_W-1:0]   w_att_next, w_def_next;
   logic [SUM_W-1:0]   w_total;
   logic [SCORE_W-1:0] w_sat;

   assign w_my_d = W'(r_my >> (32'(r_dir) * W));
   assign w_op_d = W'(r_op >> (32'(r_dir) * W));
   assign w_gr_d = W'(r_gr >> (32'(r_dir) * W));

   // The candidate cell is treated as a stone of whichever side is being viewed.
   assign w_att_code = classify(w_my_d | c_centre, w_op_d | w_gr_d);
   assign w_def_code = classify(w_op_d | c_centre, w_my_d | w_gr_d);

   assign w_att_next = r_att_acc + score_of(w_att_code);
   assign w_def_next = r_def_acc + score_of(w_def_code);

   assign w_total = SUM_W'(w_att_next) + SUM_W'(w_def_next >> DEF_SHIFT);
   assign w_sat   = (w_total > c_max) ? {SCORE_W{1'b1}} : w_total[SCORE_W-1:0];

   assign in_ready = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_dir     <= 2'd0;
         r_my      <= '0;
         r_op      <= '0;
         r_gr      <= '0;
         r_att_acc <= '0;
         r_def_acc <= '0;
         out_valid <= 1'b0;
         out_score <= '0;
         out_win   <= 1'b0;
         out_block <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_my      <= in_my;
                  r_op      <= in_op;
                  r_gr      <= in_gr;
                  r_att_acc <= '0;
                  r_def_acc <= '0;
                  r_dir     <= 2'd0;
                  out_score <= '0;
                  out_win   <= 1'b0;
                  out_block <= 1'b0;
                  if (in_my[R] || in_op[R]) begin
                     r_state   <= ST_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     r_state   <= ST_EVAL;
                  end
               end
            end
            ST_EVAL: begin
               r_att_acc <= w_att_next;
               r_def_acc <= w_def_next;
               if (w_att_code == c_five) out_win   <= 1'b1;
               if (w_def_code == c_five) out_block <= 1'b1;
               r_dir <= r_dir + 2'd1;
               if (r_dir == 2'd3) begin
                  r_state   <= ST_DONE;
                  out_valid <= 1'b1;
                  out_score <= w_sat;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/chess_line_scorer.md
# chess_line_scorer

Sequential, parametrised point evaluator for the Gobang engine. It scores one candidate board position from all four line directions (horizontal, vertical, diagonal, anti-diagonal) for both the attacking side and the defending side. It accumulates a saturated total and reports it over a valid/ready handshake. It sits between the board-window extractor and the move-selection logic, and replaces per-direction combinational scoring with one time-multiplexed evaluator.

## Interface
- R, 4, window radius; window length W = 2R+1, centre index R; legal range 3..7
- SCORE_W, 16, width of the total score
- DEF_SHIFT, 1, right shift applied to the defence sum before it is added
- S_FIVE, 2500; S_LFOUR, 216; S_SFOUR, 36; S_LTHREE, 36; S_LTWO, 6; S_LONE, 1; S_NONE, 0: per-direction pattern scores
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_my  in  4*W  own stones; direction d occupies bits [d*W +: W]
- in_op  in  4*W  opponent stones, same packing
- in_gr  in  4*W  off-board/border cells, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_score  out  SCORE_W  total score
- out_win  out  1  some direction forms a five for own side
- out_block  out  1  some direction forms a five for the opponent (forced block)

## Operation
- States: IDLE, EVAL, DONE.
- IDLE: in_ready=1. On in_valid, latch all three vectors, clear the accumulators and flags, and set dir=0.
  - If centre bit R of direction 0 is set in in_my or in_op, go straight to DONE with score 0 and both flags 0.
  - Otherwise go to EVAL.
- EVAL: each cycle evaluates direction dir, then increments dir. After dir=3, go to DONE.
- Evaluation for one direction:
  - Attack view: mine = my|centre bit, blocked = op|gr.
  - Defence view: mine = op|centre bit, blocked = my|gr.
  - empty = not mine and not blocked.
  - Every pattern window must contain index R.
- Pattern rules, in priority order; the first match gives the direction score:
  - five: 5 consecutive mine.
  - live four: 6-cell window E M M M M E.
  - sleep four: 5-cell window with 4 mine, 1 empty, 0 blocked.
  - live three: 6-cell window with both ends empty and inner 4 cells holding 3 mine and 1 empty.
  - live two: same window shape with inner 4 cells holding 2 mine and 2 empty.
  - live one: a 5-cell window with 0 blocked.
  - else S_NONE.
- Accumulators:
  - attack_acc += attack score; defence_acc += defence score.
  - out_win is set if the attack score is five; out_block is set if the defence score is five.
  - Accumulators are SCORE_W+2 bits wide.
- Total: attack_acc + (defence_acc >> DEF_SHIFT), saturated to 2^SCORE_W-1.
- DONE: out_valid=1, and outputs hold stable until out_ready. After the handshake, return to IDLE. in_ready=0 in DONE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_score=0, out_win=0, out_block=0, dir=0.
- Normal latency: accept at cycle T, EVAL during T+1..T+4, out_valid high from T+5.
- Occupied centre: out_valid high from T+1.
- Throughput: at most one request per 6 cycles. No new request is accepted in the cycle out_ready completes the handshake; in_ready rises the following cycle.
- in_ready is a pure function of state, with no combinational path from in_valid or out_ready.
- out_valid stays asserted with unchanged outputs until out_ready=1.
- Inputs change only the latched copy on acceptance. Changes to in_* at other times are ignored.
- rst during EVAL or DONE aborts the request: the next cycle is IDLE with reset values and the result discarded.
- Saturation must never wrap: the sum is computed at SCORE_W+3 bits before clamping.

## Test plan
- Reset mid-EVAL: assert rst at T+2 -> next cycle in_ready=1, out_valid=0; a following request completes normally.
- Empty board, R=4, no border, DEF_SHIFT=1:
  - Response at T+5: out_score=6 (4×1 attack + (4×1)>>1 defence), out_win=0, out_block=0.
- Own stones at horizontal indices 0..3, rest empty -> horizontal is a five.
  - Expect out_win=1 and out_score = 2500 + 3×1 attack, plus defence (4×1)>>1 = 2505.
- Opponent stones at vertical indices 5..8, own stones elsewhere none:
  - Expect out_block=1, out_win=0 and out_score = 4 + (2500 + 3)>>1 = 1255.
- Occupied centre: in_op bit R of direction 0 set -> out_valid at T+1, out_score=0, flags 0.
- Backpressure and saturation:
  - Hold out_ready=0 for 10 cycles -> out_score is stable and in_ready=0 throughout.
  - With SCORE_W=12 and an all-five stimulus -> out_score=4095.
